// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and constant helpers for the PLL lock sequencer.
// Sizing functions are evaluated at elaboration time only.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the PLL/core side (slave).
interface pll_lock_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int MAX_RETRIES = 3
);

  localparam int RETRY_W = clog2(MAX_RETRIES + 1);

  logic               pll_lock_i;
  logic               restart_i;
  logic               pll_resetb_o;
  logic               core_reset_o;
  logic               locked_o;
  logic               error_o;
  logic [RETRY_W-1:0] retry_count_o;

  modport master (
    input  pll_lock_i,
    input  restart_i,
    output pll_resetb_o,
    output core_reset_o,
    output locked_o,
    output error_o,
    output retry_count_o
  );

  modport slave (
    output pll_lock_i,
    output restart_i,
    input  pll_resetb_o,
    input  core_reset_o,
    input  locked_o,
    input  error_o,
    input  retry_count_o
  );

endinterface

// File: rtl/pll_lock_sequencer_sync_ff.sv
// Multi-stage synchroniser for a single asynchronous level, synchronous reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives iCE40 PLL RESETB, waits for a stable LOCK with bounded retries,
// then releases the core reset. Runs entirely in the reference-clock domain.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pll_lock_sequencer_if.master ctrl
);

  localparam int CNT_W   = clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));
  localparam int RETRY_W = clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pllResetb_q, pllResetb_d;
  logic               coreReset_q, coreReset_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;
  logic               lockS;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lockSync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ctrl.pll_lock_i),
    .q_o   (lockS)
  );

  // Next state, counter and retry bookkeeping; restart overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (ctrl.restart_i) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lockS) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = HOLD;
              cnt_d   = '0;
            end else begin
              state_d = FAIL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          // A drop restarts the timeout window without consuming a retry.
          if (!lockS) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lockS) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end

    pllResetb_d = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
    coreReset_d = (state_d != RUN);
    locked_d    = (state_d == RUN);
    error_d     = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      pllResetb_q <= 1'b0;
      coreReset_q <= 1'b1;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pllResetb_q <= pllResetb_d;
      coreReset_q <= coreReset_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  assign ctrl.pll_resetb_o  = pllResetb_q;
  assign ctrl.core_reset_o  = coreReset_q;
  assign ctrl.locked_o      = locked_q;
  assign ctrl.error_o       = error_q;
  assign ctrl.retry_count_o = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/age reference model predicts
// every cycle's outputs, a negedge monitor compares them against the DUT.
module tb_pll_lock_sequencer;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int LOCK_STABLE    = 8;
  localparam int MAX_RETRIES    = 2;
  localparam int SYNC_STAGES    = 2;

  localparam int M_HOLD   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAIL   = 4;

  typedef struct {
    int edgeNo;
    int resetb;
    int coreRst;
    int locked;
    int err;
    int retry;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks  = 0;
  int   errors  = 0;
  int   edgeNo  = 0;

  exp_t expQ[$];

  int mPhase;
  int mAge;
  int mRetries;
  bit lockHist[$];

  always #5 clk = ~clk;

  pll_lock_sequencer_if #(.MAX_RETRIES(MAX_RETRIES)) dutIf ();

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .LOCK_STABLE    (LOCK_STABLE),
    .MAX_RETRIES    (MAX_RETRIES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (dutIf)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeNo, got, exp);
    end
  endtask

  // Reference model: lock is seen SYNC_STAGES edges late; each phase lasts a fixed number of edges.
  task automatic modelEdge(input bit rst, input bit lock, input bit restart);
    bit ls;
    ls = lockHist.pop_front();
    lockHist.push_back(lock);
    if (rst) begin
      mPhase = M_HOLD; mAge = 0; mRetries = 0;
      lockHist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) lockHist.push_back(1'b0);
    end else if (restart) begin
      mPhase = M_HOLD; mAge = 0; mRetries = 0;
    end else begin
      case (mPhase)
        M_HOLD: begin
          mAge++;
          if (mAge == PLL_RST_CYCLES) begin mPhase = M_WAIT; mAge = 0; end
        end
        M_WAIT: begin
          mAge++;
          if (ls) begin
            mPhase = M_STABLE; mAge = 0;
          end else if (mAge == LOCK_TIMEOUT) begin
            if (mRetries < MAX_RETRIES) begin
              mRetries++; mPhase = M_HOLD; mAge = 0;
            end else begin
              mPhase = M_FAIL;
            end
          end
        end
        M_STABLE: begin
          mAge++;
          if (!ls) begin
            mPhase = M_WAIT; mAge = 0;
          end else if (mAge == LOCK_STABLE) begin
            mPhase = M_RUN; mRetries = 0;
          end
        end
        M_RUN: begin
          if (!ls) begin mPhase = M_HOLD; mAge = 0; mRetries = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit lock, input bit restart);
    exp_t e;
    @(negedge clk);
    reset = rst;
    dutIf.pll_lock_i = lock;
    dutIf.restart_i  = restart;
    @(posedge clk);
    #1;
    edgeNo = rst ? 0 : edgeNo + 1;
    modelEdge(rst, lock, restart);
    e.edgeNo  = edgeNo;
    e.resetb  = (mPhase == M_WAIT || mPhase == M_STABLE || mPhase == M_RUN) ? 1 : 0;
    e.coreRst = (mPhase == M_RUN) ? 0 : 1;
    e.locked  = (mPhase == M_RUN) ? 1 : 0;
    e.err     = (mPhase == M_FAIL) ? 1 : 0;
    e.retry   = mRetries;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   gR, gC, gL, gE, gN;
    if (expQ.size() > 0) begin
      e  = expQ.pop_front();
      gR = (dutIf.pll_resetb_o === 1'b1) ? 1 : (dutIf.pll_resetb_o === 1'b0) ? 0 : -1;
      gC = (dutIf.core_reset_o === 1'b1) ? 1 : (dutIf.core_reset_o === 1'b0) ? 0 : -1;
      gL = (dutIf.locked_o === 1'b1) ? 1 : (dutIf.locked_o === 1'b0) ? 0 : -1;
      gE = (dutIf.error_o === 1'b1) ? 1 : (dutIf.error_o === 1'b0) ? 0 : -1;
      gN = $isunknown(dutIf.retry_count_o) ? -1 : int'(dutIf.retry_count_o);
      checks++;
      if (gR != e.resetb || gC != e.coreRst || gL != e.locked || gE != e.err || gN != e.retry) begin
        errors++;
        $display("[TB] FAIL outputs edge %0d: got resetb=%0d core=%0d locked=%0d err=%0d retry=%0d, expected resetb=%0d core=%0d locked=%0d err=%0d retry=%0d",
                 e.edgeNo, gR, gC, gL, gE, gN, e.resetb, e.coreRst, e.locked, e.err, e.retry);
      end
    end
  end

  task automatic lockHighFromReset();
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 3)  checkOutput("resetb low edge 3", dutIf.pll_resetb_o, 0);
      if (k == 4)  checkOutput("resetb high edge 4", dutIf.pll_resetb_o, 1);
      if (k == 12) checkOutput("locked edge 12", dutIf.locked_o, 0);
      if (k == 13) begin
        checkOutput("locked edge 13", dutIf.locked_o, 1);
        checkOutput("core reset edge 13", dutIf.core_reset_o, 0);
        checkOutput("retry edge 13", dutIf.retry_count_o, 0);
      end
    end
  endtask

  initial begin
    int  segLeft;
    bit  lvl;
    bit  rst;
    bit  rsr;

    reset = 1'b1;
    dutIf.pll_lock_i = 1'b0;
    dutIf.restart_i  = 1'b0;
    mPhase = M_HOLD; mAge = 0; mRetries = 0;
    for (int i = 0; i < SYNC_STAGES; i++) lockHist.push_back(1'b0);

    // Lock tied high from reset.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset resetb", dutIf.pll_resetb_o, 0);
    checkOutput("reset core", dutIf.core_reset_o, 1);
    lockHighFromReset();
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);

    // Lock drops in RUN, then returns.
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("core reset after drop", dutIf.core_reset_o, 1);
    checkOutput("locked after drop", dutIf.locked_o, 0);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("relocked", dutIf.locked_o, 1);

    // Lock never asserts: two retries then FAIL.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 108; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (k == 35)  checkOutput("retry edge 35", dutIf.retry_count_o, 0);
      if (k == 36)  checkOutput("retry edge 36", dutIf.retry_count_o, 1);
      if (k == 39)  checkOutput("resetb edge 39", dutIf.pll_resetb_o, 0);
      if (k == 40)  checkOutput("resetb edge 40", dutIf.pll_resetb_o, 1);
      if (k == 72)  checkOutput("retry edge 72", dutIf.retry_count_o, 2);
      if (k == 107) checkOutput("error edge 107", dutIf.error_o, 0);
      if (k == 108) begin
        checkOutput("error edge 108", dutIf.error_o, 1);
        checkOutput("resetb in fail", dutIf.pll_resetb_o, 0);
      end
    end
    repeat (200) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fail sticky", dutIf.error_o, 1);

    // Restart out of FAIL with lock high.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("error after restart", dutIf.error_o, 0);
    checkOutput("retry after restart", dutIf.retry_count_o, 0);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 12) checkOutput("locked restart+12", dutIf.locked_o, 0);
      if (k == 13) checkOutput("locked restart+13", dutIf.locked_o, 1);
    end

    // One-cycle lock glitch during STABLE.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1'b0, (k == 7) ? 1'b0 : 1'b1, 1'b0);
      if (k == 17) checkOutput("glitch locked edge 17", dutIf.locked_o, 0);
      if (k == 18) begin
        checkOutput("glitch locked edge 18", dutIf.locked_o, 1);
        checkOutput("glitch retry", dutIf.retry_count_o, 0);
      end
    end

    // Reset mid-STABLE, then the nominal sequence again.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midreset resetb", dutIf.pll_resetb_o, 0);
    checkOutput("midreset core", dutIf.core_reset_o, 1);
    checkOutput("midreset locked", dutIf.locked_o, 0);
    lockHighFromReset();

    // Randomised lock segments with occasional restart and reset.
    segLeft = 0;
    lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (segLeft == 0) begin
        lvl = ~lvl;
        if (lvl) segLeft = $urandom_range(1, 60);
        else segLeft = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 300) : $urandom_range(1, 40);
      end
      segLeft--;
      rsr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus(rst, lvl, rsr);
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
